// File: rtl/ps2_pkg.sv
// Shared widths and types for the PS/2 keyboard to display-RAM loader.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_BCNT_W     = 4;
  localparam int unsigned RAM_ADDR_W     = 3;
  localparam int unsigned RAM_DATA_W     = 8;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  // Bit-counter landmarks within one frame: start, data 1..8, parity, stop.
  localparam logic [PS2_BCNT_W-1:0] BCNT_LAST_DATA = PS2_BCNT_W'(RAM_DATA_W);
  localparam logic [PS2_BCNT_W-1:0] BCNT_PARITY    = PS2_BCNT_W'(PS2_FRAME_BITS - 2);

endpackage

// File: rtl/ps2_byte_fifo.sv
// Circular byte FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  ram_data_t                     push_data_i,
  input  logic                          pop_i,
  output ram_data_t                     pop_data_c_o,
  output logic                          full_c_o,
  output logic                          empty_c_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ram_data_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_ok_c;
  logic                   pop_ok_c;

  assign full_c_o     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c_o    = (count_q == '0);
  assign pop_data_c_o = mem_q[rptr_q];
  assign count_o      = count_q;

  // Pop is resolved first, so it frees a slot for a same-cycle push.
  assign pop_ok_c  = pop_i & ~empty_c_o;
  assign push_ok_c = push_i & (~full_c_o | pop_ok_c);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    if (push_ok_c) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok_c)  rptr_d = rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_ram_loader.sv
// PS/2 receiver feeding a byte FIFO that drains into the 8x8 display RAM write port.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd.
module ps2_ram_loader
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          wr_en,
  output logic                          we,
  output ram_addr_t                     inaddr,
  output ram_data_t                     din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  // Synchronizers reset to the idle-high line level so reset release makes no edge.
  logic [2:0]             ps2_clk_sync_q;
  logic [1:0]             ps2_data_sync_q;
  logic                   fe_c;
  logic                   bit_c;

  logic [PS2_BCNT_W-1:0]  bcnt_q, bcnt_d;
  ram_data_t              shift_q, shift_d;
`ifdef PS2_PARITY_CHECK_EN
  logic                   parity_q, parity_d;
`endif
  logic                   push_c;
  logic                   frame_bad_c;
  logic                   stop_ok_c;

  ram_data_t              head_c;
  logic                   full_c;
  logic                   empty_c;
  logic                   pop_c;

  logic                   we_q, we_d;
  ram_addr_t              inaddr_q, inaddr_d;
  ram_data_t              din_q, din_d;
  ram_addr_t              wptr_q, wptr_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  assign fe_c  = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
  assign bit_c = ps2_data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign stop_ok_c = bit_c & (^{shift_q, parity_q});
`else
  assign stop_ok_c = bit_c;
`endif

  // Frame receiver: every action is gated by the synchronized falling edge.
  always_comb begin
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    push_c      = 1'b0;
    frame_bad_c = 1'b0;
    if (fe_c) begin
      if (bcnt_q == '0) begin
        if (!bit_c) bcnt_d = PS2_BCNT_W'(1);
      end else if (bcnt_q <= BCNT_LAST_DATA) begin
        shift_d = {bit_c, shift_q[RAM_DATA_W-1:1]};
        bcnt_d  = bcnt_q + PS2_BCNT_W'(1);
      end else if (bcnt_q == BCNT_PARITY) begin
`ifdef PS2_PARITY_CHECK_EN
        parity_d = bit_c;
`endif
        bcnt_d   = bcnt_q + PS2_BCNT_W'(1);
      end else begin
        bcnt_d      = '0;
        push_c      = stop_ok_c;
        frame_bad_c = ~stop_ok_c;
      end
    end
  end

  ps2_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_c),
    .push_data_i  (shift_q),
    .pop_i        (pop_c),
    .pop_data_c_o (head_c),
    .full_c_o     (full_c),
    .empty_c_o    (empty_c),
    .count_o      (fifo_count)
  );

  assign pop_c = wr_en & ~empty_c;

  // Writer: a pop this cycle becomes a RAM write strobe next cycle.
  always_comb begin
    we_d        = pop_c;
    inaddr_d    = inaddr_q;
    din_d       = din_q;
    wptr_d      = wptr_q;
    overflow_d  = overflow_q | (push_c & full_c & ~pop_c);
    frame_err_d = frame_err_q | frame_bad_c;
    if (pop_c) begin
      din_d    = head_c;
      inaddr_d = wptr_q;
      wptr_d   = wptr_q + RAM_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_sync_q  <= '1;
      ps2_data_sync_q <= '1;
      bcnt_q          <= '0;
      shift_q         <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q        <= 1'b0;
`endif
      we_q            <= 1'b0;
      inaddr_q        <= '0;
      din_q           <= '0;
      wptr_q          <= '0;
      overflow_q      <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[1:0], ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
      bcnt_q          <= bcnt_d;
      shift_q         <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q        <= parity_d;
`endif
      we_q            <= we_d;
      inaddr_q        <= inaddr_d;
      din_q           <= din_d;
      wptr_q          <= wptr_d;
      overflow_q      <= overflow_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign we        = we_q;
  assign inaddr    = inaddr_q;
  assign din       = din_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_ram_loader.sv
// Scoreboard bench for ps2_ram_loader: PS/2 frames in, expected RAM writes queued and matched.
// Expectations follow PS2_PARITY_CHECK_EN the same way the design build does.
module tb_ps2_ram_loader;
  import ps2_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          ps2_clk;
  logic          ps2_data;
  logic          wr_en;
  logic          we;
  ram_addr_t     inaddr;
  ram_data_t     din;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;

  ps2_ram_loader #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .wr_en      (wr_en),
    .we         (we),
    .inaddr     (inaddr),
    .din        (din),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: bytes accepted but not yet seen on the RAM port.
  logic [7:0] exp_q[$];
  int         model_waddr = 0;
  bit         model_ovf = 1'b0;
  bit         model_ferr = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         writes_seen = 0;
  int         last_we_cyc = 0;
  int         last_fall_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected byte at the next address.
  always @(posedge clk) begin
    #1;
    if (!rst && we === 1'b1) begin
      writes_seen++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", int'(din), -1);
      end else begin
        check("din", int'(din), int'(exp_q.pop_front()));
        check("inaddr", int'(inaddr), model_waddr % 8);
        model_waddr++;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    model_waddr = 0;
    model_ovf   = 1'b0;
    model_ferr  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk); #3;
    ps2_data = b;
    #50;
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    #100;
    ps2_clk = 1'b1;
    #40;
  endtask

  // Frame acceptance decided from the frame rules and current model occupancy.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    bit ok;
`ifdef PS2_PARITY_CHECK_EN
    ok = stop && ((^{d, par}) == 1'b1);
`else
    ok = stop;
`endif
    if (!ok) model_ferr = 1'b1;
    else if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(d);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    logic stop;
    par  = ~(^d) ^ bad_par;
    stop = ~bad_stop;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    model_frame(d, par, stop);
    drive_bit(stop);
    ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, int'(fifo_count), exp_q.size());
    check({tag, "_overflow"}, int'(overflow), int'(model_ovf));
    check({tag, "_frame_err"}, int'(frame_err), int'(model_ferr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int run;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wr_en    = 1'b1;

    apply_reset();
    @(posedge clk); #1;
    check("rst_we", int'(we), 0);
    check("rst_inaddr", int'(inaddr), 0);
    check("rst_din", int'(din), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_err", int'(frame_err), 0);

    // Single frame and its stop-edge-to-write latency.
    w0 = writes_seen;
    send_frame(8'h1C, 1'b0, 1'b0);
    settle();
    check_state("single");
    check("single_writes", writes_seen - w0, 1);
    check("single_latency", last_we_cyc - last_fall_cyc, 4);
    check("single_hold_din", int'(din), 'h1C);

    // Nine frames wrap the write address back to 0.
    apply_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    settle();
    check_state("wrap");
    check("wrap_last_addr", int'(inaddr), 0);
    check("wrap_last_din", int'(din), 9);

    // Overflow with writes held, then a back-to-back drain of eight bytes.
    apply_reset();
    @(posedge clk); #3;
    wr_en = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    settle();
    check("ovf_count_full", int'(fifo_count), 8);
    check("ovf_flag", int'(overflow), 1);
    check_state("ovf");
    @(posedge clk); #3;
    wr_en = 1'b1;
    for (int i = 0; i < 20 && we !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    run = 0;
    while (we === 1'b1 && run < 20) begin
      run++;
      @(posedge clk); #1;
    end
    check("ovf_burst_len", run, 8);
    settle();
    check_state("ovf_drained");

    // Bad stop bit is dropped; a following good frame still lands at address 0.
    apply_reset();
    w0 = writes_seen;
    send_frame(8'h55, 1'b0, 1'b1);
    settle();
    check("badstop_frame_err", int'(frame_err), 1);
    check("badstop_writes", writes_seen - w0, 0);
    send_frame(8'h3A, 1'b0, 1'b0);
    settle();
    check_state("badstop");
    check("badstop_next_addr", int'(inaddr), 0);
    check("badstop_next_din", int'(din), 'h3A);

    // Bad parity behaviour depends on the build option.
    apply_reset();
    w0 = writes_seen;
    send_frame(8'h1C, 1'b1, 1'b0);
    settle();
    check_state("badpar");
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_frame_err", int'(frame_err), 1);
    check("badpar_writes", writes_seen - w0, 0);
`else
    check("badpar_frame_err", int'(frame_err), 0);
    check("badpar_writes", writes_seen - w0, 1);
`endif

    // Reset after five data bits discards the partial frame.
    apply_reset();
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    apply_reset();
    w0 = writes_seen;
    send_frame(8'h7E, 1'b0, 1'b0);
    settle();
    check_state("midrst");
    check("midrst_writes", writes_seen - w0, 1);
    check("midrst_addr", int'(inaddr), 0);

    // Random bytes, random frame errors and random write-enable gating.
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #3;
        wr_en = ~wr_en;
      end
      send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    @(posedge clk); #3;
    wr_en = 1'b1;
    settle();
    check_state("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
